// File: rtl/temporizador_regressivo.sv
// Countdown timer: loads D, then decrements Q once every PRESCALE counting
// cycles until it reaches zero, where it raises and holds done.
module temporizador_regressivo #(
    parameter int WIDTH    = 16,
    parameter int PRESCALE = 50000
) (
    input  logic             clock,
    input  logic             clr,
    input  logic             ld,
    input  logic             start,
    input  logic             pause,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             tick,
    output logic             done,
    output logic             running
);

    typedef enum logic [1:0] {
        PARADO   = 2'd0,
        CONTANDO = 2'd1,
        PAUSADO  = 2'd2,
        EXPIRADO = 2'd3
    } estado_t;

    localparam logic [15:0] PRESC_MAX = 16'(PRESCALE - 1);

    estado_t          estado_q;
    logic [15:0]      presc_q;
    logic [WIDTH-1:0] q_q;
    logic             tick_q;
    logic             done_q;

    // NOTE: all state lives in this one clocked block and uses non-blocking
    // assignments, so every branch reads the pre-edge values of the registers.
    always_ff @(posedge clock or negedge clr) begin
        if (!clr) begin
            estado_q <= PARADO;
            presc_q  <= '0;
            q_q      <= '0;
            tick_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (!ld) begin
            estado_q <= PARADO;
            presc_q  <= '0;
            q_q      <= D;
            tick_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (estado_q)
                PARADO: begin
                    tick_q <= 1'b0;
                    if (start) begin
                        if (q_q != '0) begin
                            estado_q <= CONTANDO;
                            presc_q  <= '0;
                        end else begin
                            estado_q <= EXPIRADO;
                            done_q   <= 1'b1;
                        end
                    end
                end
                // The cycle that releases pause already counts, so the total
                // elapsed cycles exclude exactly the cycles with pause high.
                CONTANDO, PAUSADO: begin
                    if (pause) begin
                        estado_q <= PAUSADO;
                        tick_q   <= 1'b0;
                    end else if (presc_q == PRESC_MAX) begin
                        presc_q <= '0;
                        q_q     <= q_q - WIDTH'(1);
                        tick_q  <= 1'b1;
                        if (q_q == WIDTH'(1)) begin
                            estado_q <= EXPIRADO;
                            done_q   <= 1'b1;
                        end else begin
                            estado_q <= CONTANDO;
                        end
                    end else begin
                        presc_q  <= presc_q + 16'd1;
                        tick_q   <= 1'b0;
                        estado_q <= CONTANDO;
                    end
                end
                EXPIRADO: begin
                    tick_q <= 1'b0;
                    done_q <= 1'b1;
                end
                default: estado_q <= PARADO;
            endcase
        end
    end

    assign Q       = q_q;
    assign tick    = tick_q;
    assign done    = done_q;
    assign running = (estado_q == CONTANDO);

endmodule

// File: doc/temporizador_regressivo.md
Name: temporizador_regressivo

Overview:
- Down-counting countdown timer; the counterpart to the up-counting tick counter.
- Loads a start value, then decrements it once per prescaled time unit (PRESCALE clock cycles) until it reaches zero.
- At zero it asserts `done` and holds it.
- Sits in the game/experiment datapath as the time-limit block: the control unit loads, starts and pauses it, and watches `done` and `tick`.

Parameters:
- WIDTH, 16, bit width of the loaded value and of the count output `Q`.
- PRESCALE, 50000, clock cycles per decrement (1 ms at 50 MHz); legal range 1..65535.

Ports:
- clock, input, 1, system clock; all state updates on the rising edge.
- clr, input, 1, asynchronous active-low reset.
- ld, input, 1, synchronous active-low load of D into Q.
- start, input, 1, active-high start request.
- pause, input, 1, active-high level hold; counting freezes while it is high.
- D, input, WIDTH, value loaded into Q.
- Q, output, WIDTH, remaining time units (registered).
- tick, output, 1, registered one-cycle pulse on every decrement.
- done, output, 1, registered level; high while in EXPIRADO.
- running, output, 1, high while in CONTANDO (decoded from the state register).

Behaviour:
- Reset:
  - One clock; reset is asynchronous and active-low (`clr`); clock port is `clock`.
  - `clr` low forces, immediately and independent of `clock`: state PARADO, Q=0, prescaler=0, tick=0, done=0, running=0.
  - Reset mid-count discards all progress.
- Internal prescaler:
  - 16-bit counter, 0..PRESCALE-1.
  - Advances only in CONTANDO.
  - Cleared on load and on entry to CONTANDO from PARADO.
  - Frozen (value kept) in PAUSADO.
- Priority per edge: `clr` > `ld` low > state transitions.
- Load (`ld` low, any state):
  - Q<=D, prescaler<=0, done<=0, tick<=0, state<=PARADO.
  - `start` and `pause` are ignored in that cycle.
- PARADO:
  - `start`=1 and Q!=0 -> CONTANDO, prescaler<=0.
  - `start`=1 and Q==0 -> EXPIRADO, done<=1, no tick.
  - Otherwise stay; Q held.
- CONTANDO:
  - `pause`=1 -> PAUSADO; prescaler and Q hold; no tick that cycle.
  - Else, if prescaler==PRESCALE-1: prescaler<=0, Q<=Q-1, tick<=1.
  - If additionally Q==1: state<=EXPIRADO and done<=1 on that same edge, so tick and done rise together.
  - Else prescaler<=prescaler+1, tick<=0.
  - `start` is ignored.
- PAUSADO:
  - `pause`=0 -> CONTANDO; the prescaler resumes from its held value, so total counted cycles exclude paused cycles.
  - `start` is ignored.
- EXPIRADO:
  - Q=0, done=1, tick=0 after the first cycle.
  - Leaves only via `ld` low or `clr`; `start` and `pause` are ignored.
- Timing:
  - First decrement occurs PRESCALE rising edges after the edge that enters CONTANDO.
  - N loaded units expire after exactly N*PRESCALE counting cycles.
- Q never wraps below 0; no decrement occurs in any state other than CONTANDO.
- PRESCALE=1: Q decrements on every CONTANDO cycle and tick stays high continuously.
- `running` = (state==CONTANDO); it is low in PAUSADO.

Test Plan:
- PRESCALE=4: `clr` pulse mid-simulation, asynchronously between edges -> Q=0, done=0, tick=0, running=0 immediately, before the next edge.
- PRESCALE=4, D=3, `ld` low 1 cycle, `start` 1 cycle -> tick pulses at cycles 4, 8, 12 after start; Q goes 3→2→1→0; done and running change at cycle 12; done stays 1 for 20 further cycles.
- PRESCALE=4, D=2: start, hold `pause` high for 5 cycles starting 2 cycles in -> first tick delayed to cycle 9; Q unchanged during pause; running=0 while paused; done at cycle 13.
- D=0: `ld` low then `start` -> done=1 next edge, no tick, Q stays 0.
- Mid-count with Q=5: assert `ld` low with D=7 -> Q=7, state PARADO, done=0, prescaler cleared; a following `start` gives the first tick 4 cycles later.
- In EXPIRADO: pulse `start` and `pause` -> no change; then `ld` low with D=1 and `start` -> done falls on load, re-rises 4 cycles after start.
